// File: rtl/program_loader.sv
// Host-link program loader: length-prefixed byte stream -> little-endian words into main_memory.
// Optional trailing checksum word enabled by defining LOADER_CHECKSUM_EN.
module program_loader #(
    parameter logic [31:0] BASE_ADDR = 32'd0,
    parameter int          DEPTH     = 2048
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic        mem_wen,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, DONE, ERR, CHK} state_t;
`else
    typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, DONE, ERR} state_t;
`endif

    state_t      state, state_n;
    logic [1:0]  byte_cnt;
    logic [31:0] word_idx;
    logic [31:0] len_q;
    logic [31:0] asm_q;
    logic [31:0] word_in;
    logic        xfer;
    logic        last_byte;
    logic        restart;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0] sum_q;
`endif

    // word_in is the complete word as it will be once the current byte lands
    assign word_in   = {in_data, asm_q[23:0]};
    assign last_byte = (byte_cnt == 2'd3);
    assign restart   = start && (state == IDLE || state == DONE || state == ERR);

`ifdef LOADER_CHECKSUM_EN
    assign in_ready = (state == LEN) || (state == DATA) || (state == CHK);
    assign cpu_hold = (state == LEN) || (state == DATA) || (state == WRITE) || (state == CHK);
`else
    assign in_ready = (state == LEN) || (state == DATA);
    assign cpu_hold = (state == LEN) || (state == DATA) || (state == WRITE);
`endif
    assign xfer    = in_valid && in_ready;
    assign mem_wen = (state == WRITE);
    assign done    = (state == DONE);
    assign error   = (state == ERR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE, ERR: if (start) state_n = LEN;
            LEN: if (xfer && last_byte) begin
`ifdef LOADER_CHECKSUM_EN
                if (word_in == 32'd0)             state_n = CHK;
`else
                if (word_in == 32'd0)             state_n = DONE;
`endif
                else if (word_in > 32'(DEPTH))    state_n = ERR;
                else                              state_n = DATA;
            end
            DATA: if (xfer && last_byte) state_n = WRITE;
            WRITE: begin
`ifdef LOADER_CHECKSUM_EN
                if (word_idx + 32'd1 == len_q) state_n = CHK;
`else
                if (word_idx + 32'd1 == len_q) state_n = DONE;
`endif
                else                           state_n = DATA;
            end
`ifdef LOADER_CHECKSUM_EN
            CHK: if (xfer && last_byte) state_n = (word_in == sum_q) ? DONE : ERR;
`endif
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_cnt  <= '0;
            word_idx  <= '0;
            len_q     <= '0;
            asm_q     <= '0;
            mem_waddr <= '0;
            mem_wdata <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum_q     <= '0;
`endif
        end else begin
            if (restart) begin
                byte_cnt <= '0;
                word_idx <= '0;
                len_q    <= '0;
                asm_q    <= '0;
`ifdef LOADER_CHECKSUM_EN
                sum_q    <= '0;
`endif
            end
            // byte counter wraps after 4, so each phase starts at lane 0
            if (xfer) begin
                byte_cnt                   <= byte_cnt + 2'd1;
                asm_q[{byte_cnt, 3'b000} +: 8] <= in_data;
            end
            if (state == LEN && xfer && last_byte) len_q <= word_in;
            // address/data registered early so they are valid throughout WRITE
            if (state == DATA && xfer && last_byte) begin
                mem_waddr <= BASE_ADDR + word_idx;
                mem_wdata <= word_in;
            end
            if (state == WRITE) begin
                word_idx <= word_idx + 32'd1;
`ifdef LOADER_CHECKSUM_EN
                sum_q    <= sum_q + mem_wdata;
`endif
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed, table-driven bench for program_loader (default build or LOADER_CHECKSUM_EN).
module tb_program_loader;
    logic        clk, rst, start, in_valid;
    logic [7:0]  in_data;
    logic        in_ready, mem_wen, cpu_hold, done, error;
    logic [31:0] mem_waddr, mem_wdata;

    int total = 0;
    int fails = 0;
    int wr_count = 0;

    program_loader #(.BASE_ADDR(32'd0), .DEPTH(2048)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_wen(mem_wen), .cpu_hold(cpu_hold), .done(done), .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (rst && mem_wen) wr_count++;

    typedef struct {
        logic [31:0] len;
        logic [31:0] w0;
        logic [31:0] w1;
        int          nwords;
        bit          gap;
        bit          bad_ck;
        bit          exp_done;
        bit          exp_err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n = 0;
        if (gap) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 20) begin
                total++; fails++;
                $display("FAIL send_byte timeout: in_ready stuck at 0, expected 1");
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], gap);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        logic [31:0] sum;
        logic [31:0] w;
        sum = 32'd0;
        wr_count = 0;
        pulse_start();
        check({tag, " hold_after_start"}, {31'd0, cpu_hold}, 32'd1);
        check({tag, " flags_cleared"}, {30'd0, done, error}, 32'd0);
        send_word(v.len, v.gap);
        for (int i = 0; i < v.nwords; i++) begin
            w = (i == 0) ? v.w0 : v.w1;
            sum = sum + w;
            send_word(w, v.gap);
            check({tag, " wen"}, {31'd0, mem_wen}, 32'd1);
            check({tag, " ready_in_write"}, {31'd0, in_ready}, 32'd0);
            check({tag, " waddr"}, mem_waddr, i);
            check({tag, " wdata"}, mem_wdata, w);
        end
`ifdef LOADER_CHECKSUM_EN
        if (v.len <= 32'd2048) send_word(sum + {31'd0, v.bad_ck}, v.gap);
`else
        if (v.nwords > 0) begin
            @(posedge clk); #1;
        end
`endif
        check({tag, " done"}, {31'd0, done}, {31'd0, v.exp_done});
        check({tag, " error"}, {31'd0, error}, {31'd0, v.exp_err});
        check({tag, " hold_end"}, {31'd0, cpu_hold}, 32'd0);
        check({tag, " ready_end"}, {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        check({tag, " sticky"}, {30'd0, done, error}, {30'd0, v.exp_done, v.exp_err});
        check({tag, " writes"}, wr_count, v.nwords);
    endtask

    vec_t vecs[$];

    initial begin
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        vecs.push_back('{32'd2,          32'h12345678, 32'hDEADBEEF, 2, 1'b0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{32'd0,          32'h0,        32'h0,        0, 1'b0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{32'd2049,       32'h0,        32'h0,        0, 1'b0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{32'd1,          32'hCAFEF00D, 32'h0,        1, 1'b1, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{32'hFFFF_FFFF,  32'h0,        32'h0,        0, 1'b0, 1'b0, 1'b0, 1'b1});
`ifdef LOADER_CHECKSUM_EN
        vecs.push_back('{32'd2,          32'd1,        32'd2,        2, 1'b0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{32'd2,          32'd1,        32'd2,        2, 1'b0, 1'b1, 1'b0, 1'b1});
`endif

        #12;
        check("reset_outputs", {mem_waddr[3:0], mem_wdata[3:0], in_ready, mem_wen, cpu_hold, done, error},
              32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("idle_outputs", {27'd0, in_ready, mem_wen, cpu_hold, done, error}, 32'd0);

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // reset mid-load: two data bytes in, then async reset
        pulse_start();
        send_word(32'd1, 1'b0);
        send_byte(8'hA5, 1'b0);
        send_byte(8'hA5, 1'b0);
        rst = 1'b0;
        #2;
        check("rst_mid_ctrl", {27'd0, in_ready, mem_wen, cpu_hold, done, error}, 32'd0);
        check("rst_mid_waddr", mem_waddr, 32'd0);
        check("rst_mid_wdata", mem_wdata, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        run_vec('{32'd1, 32'hA5A5A5A5, 32'h0, 1, 1'b0, 1'b0, 1'b1, 1'b0}, "after_rst");

        // L == DEPTH accepted; start during DATA must not restart the load
        pulse_start();
        send_word(32'd2048, 1'b0);
        check("depth_ok_ready", {30'd0, in_ready, cpu_hold}, 32'd3);
        check("depth_ok_noerr", {31'd0, error}, 32'd0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        pulse_start();
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        check("ign_start_wen", {31'd0, mem_wen}, 32'd1);
        check("ign_start_waddr", mem_waddr, 32'd0);
        check("ign_start_wdata", mem_wdata, 32'h44332211);
        @(posedge clk); #1;
        check("ign_start_data", {30'd0, in_ready, cpu_hold}, 32'd3);
        rst = 1'b0;
        #2;
        rst = 1'b1;

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end
endmodule
